wb_arbiter: RTL and testbench

//   Shares the single writeback broadcast bus (wb_valid/wb_error/wb_robid/wb_rd/wb_result)

---
 rtl/wb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares one registered writeback bus among NREQ functional units.
// Each unit owns a one-entry holding buffer. A round-robin scheduler picks one
// full buffer per cycle, and that buffer is driven onto the registered bus.
// rob_flush discards every buffered result and any beat that has not yet been
// launched.
module wb_arbiter #(
    parameter int NREQ = 4,
    parameter int PTRW = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_error,
    input  logic [7*NREQ-1:0]    req_robid,
    input  logic [6*NREQ-1:0]    req_rd,
    input  logic [32*NREQ-1:0]   req_result,
    input  logic                 rob_flush,
    output logic                 wb_valid,
    output logic                 wb_error,
    output logic [6:0]           wb_robid,
    output logic [5:0]           wb_rd,
    output logic [31:0]          wb_result,
    output logic [PTRW-1:0]      wb_src
);

    // Unpacked views of the flattened request fields.
    logic [6:0]  in_robid  [NREQ];
    logic [5:0]  in_rd     [NREQ];
    logic [31:0] in_result [NREQ];

    // Holding buffers: one entry per requester.
    logic [NREQ-1:0] buf_valid_q;
    logic [NREQ-1:0] buf_error_q;
    logic [6:0]      buf_robid_q  [NREQ];
    logic [5:0]      buf_rd_q     [NREQ];
    logic [31:0]     buf_result_q [NREQ];

    // Round-robin pointer: the position that gets first look next cycle.
    logic [PTRW-1:0] rr_ptr_q;
    logic [PTRW-1:0] rr_ptr_d;

    // Arbitration results and the selected buffer contents.
    logic [NREQ-1:0] grant;
    logic            grant_any;
    logic [PTRW-1:0] grant_idx;
    logic            sel_error;
    logic [6:0]      sel_robid;
    logic [5:0]      sel_rd;
    logic [31:0]     sel_result;
    logic [NREQ-1:0] handshake;

    // Registered bus stage.
    logic            wb_valid_q;
    logic            wb_error_q;
    logic [6:0]      wb_robid_q;
    logic [5:0]      wb_rd_q;
    logic [31:0]     wb_result_q;
    logic [PTRW-1:0] wb_src_q;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign in_robid[gi]  = req_robid[7*gi +: 7];
            assign in_rd[gi]     = req_rd[6*gi +: 6];
            assign in_result[gi] = req_result[32*gi +: 32];
        end
    endgenerate

    // Round-robin pick: scan rr_ptr, rr_ptr+1, ... and take the first full
    // buffer. Depends only on buffer state and the pointer, so req_valid
    // never feeds back into req_ready through grant.
    always_comb begin
        grant      = '0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        sel_error  = 1'b0;
        sel_robid  = '0;
        sel_rd     = '0;
        sel_result = '0;
        if (!rob_flush) begin
            for (int off = 0; off < NREQ; off++) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!grant_any && buf_valid_q[i] &&
                        ((int'(rr_ptr_q) + off) % NREQ) == i) begin
                        grant[i]   = 1'b1;
                        grant_any  = 1'b1;
                        grant_idx  = PTRW'(i);
                        sel_error  = buf_error_q[i];
                        sel_robid  = buf_robid_q[i];
                        sel_rd     = buf_rd_q[i];
                        sel_result = buf_result_q[i];
                    end
                end
            end
        end
    end

    // Pointer advances past the winner; it holds when nothing is granted.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = PTRW'((int'(grant_idx) + 1) % NREQ);
        end
    end

    // A buffer can accept when empty or when it is being drained this cycle.
    assign req_ready = {NREQ{rst & ~rob_flush}} & (~buf_valid_q | grant);
    assign handshake = req_valid & req_ready;

    // Buffer fill/drain; a same-cycle refill beats the drain.
    always_ff @(posedge clk) begin
        if (!rst || rob_flush) begin
            buf_valid_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (handshake[i]) begin
                    buf_valid_q[i]  <= 1'b1;
                    buf_error_q[i]  <= req_error[i];
                    buf_robid_q[i]  <= in_robid[i];
                    buf_rd_q[i]     <= in_rd[i];
                    buf_result_q[i] <= in_result[i];
                end else if (grant[i]) begin
                    buf_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer register; flush leaves it untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Bus stage: one-cycle pulse per grant, fields hold between beats.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_valid_q  <= 1'b0;
            wb_error_q  <= 1'b0;
            wb_robid_q  <= '0;
            wb_rd_q     <= '0;
            wb_result_q <= '0;
            wb_src_q    <= '0;
        end else begin
            wb_valid_q <= grant_any;
            if (grant_any) begin
                wb_error_q  <= sel_error;
                wb_robid_q  <= sel_robid;
                wb_rd_q     <= sel_rd;
                wb_result_q <= sel_result;
                wb_src_q    <= grant_idx;
            end
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_error  = wb_error_q;
    assign wb_robid  = wb_robid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_result = wb_result_q;
    assign wb_src    = wb_src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all continuously compared against a behavioural model.
module tb_wb_arbiter;
    localparam int NREQ = 4;
    localparam int PTRW = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_error;
    logic [7*NREQ-1:0]    req_robid;
    logic [6*NREQ-1:0]    req_rd;
    logic [32*NREQ-1:0]   req_result;
    logic                 rob_flush;
    logic                 wb_valid;
    logic                 wb_error;
    logic [6:0]           wb_robid;
    logic [5:0]           wb_rd;
    logic [31:0]          wb_result;
    logic [PTRW-1:0]      wb_src;

    always #5 clk = ~clk;

    wb_arbiter #(.NREQ(NREQ), .PTRW(PTRW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_error(req_error),
        .req_robid(req_robid), .req_rd(req_rd), .req_result(req_result),
        .rob_flush(rob_flush),
        .wb_valid(wb_valid), .wb_error(wb_error), .wb_robid(wb_robid),
        .wb_rd(wb_rd), .wb_result(wb_result), .wb_src(wb_src)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit        err;
        bit [6:0]  robid;
        bit [5:0]  rd;
        bit [31:0] res;
    } beat_t;

    beat_t held [NREQ];
    bit    full [NREQ];
    int    ptr;
    beat_t exp_beat;
    bit    exp_valid;
    int    exp_src;
    bit    live = 0;

    // First full holder at or after the pointer, -1 if none or blocked.
    function automatic int winner();
        if (!rst || rob_flush) return -1;
        for (int off = 0; off < NREQ; off++) begin
            if (full[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit model_ready(input int i);
        return rst && !rob_flush && (!full[i] || winner() == i);
    endfunction

    always @(posedge clk) begin
        int w;
        bit hs_m [NREQ];
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) full[i] = 0;
            ptr = 0;
            exp_valid = 0;
            exp_src = 0;
            exp_beat.err = 0; exp_beat.robid = 0; exp_beat.rd = 0; exp_beat.res = 0;
            live = 1;
        end else if (live) begin
            w = winner();
            for (int i = 0; i < NREQ; i++) hs_m[i] = req_valid[i] && model_ready(i);
            exp_valid = (w >= 0);
            if (w >= 0) begin
                exp_beat = held[w];
                exp_src = w;
                ptr = (w + 1) % NREQ;
            end
            if (rob_flush) begin
                for (int i = 0; i < NREQ; i++) full[i] = 0;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (hs_m[i]) begin
                        held[i].err   = req_error[i];
                        held[i].robid = req_robid[7*i +: 7];
                        held[i].rd    = req_rd[6*i +: 6];
                        held[i].res   = req_result[32*i +: 32];
                        full[i] = 1;
                    end else if (i == w) begin
                        full[i] = 0;
                    end
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (live) begin
            check("wb_valid", 64'(wb_valid), 64'(exp_valid));
            check("wb_src", 64'(wb_src), 64'(exp_src));
            check("wb_error", 64'(wb_error), 64'(exp_beat.err));
            check("wb_robid", 64'(wb_robid), 64'(exp_beat.robid));
            check("wb_rd", 64'(wb_rd), 64'(exp_beat.rd));
            check("wb_result", 64'(wb_result), 64'(exp_beat.res));
            for (int i = 0; i < NREQ; i++)
                check($sformatf("req_ready[%0d]", i), 64'(req_ready[i]), 64'(model_ready(i)));
            if (wb_valid)
                $display("beat t=%0t src=%0d robid=%02h rd=%02h err=%0d result=%08h",
                         $time, wb_src, wb_robid, wb_rd, wb_error, wb_result);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_error = '0; req_robid = '0; req_rd = '0; req_result = '0;
        rob_flush = 1'b0;
    endtask

    task automatic drive(input int i, input bit err, input bit [6:0] robid,
                         input bit [5:0] rd, input bit [31:0] res);
        req_valid[i] = 1'b1;
        req_error[i] = err;
        req_robid[7*i +: 7] = robid;
        req_rd[6*i +: 6] = rd;
        req_result[32*i +: 32] = res;
    endtask

    // Leaves the bench in "cycle 0": first cycle with rst high.
    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();

        // Test 1: single request, 2-cycle latency.
        do_reset();
        #1;
        check("t1 reset wb_valid", 64'(wb_valid), 0);
        check("t1 reset wb_robid", 64'(wb_robid), 0);
        check("t1 reset wb_rd", 64'(wb_rd), 0);
        check("t1 reset wb_result", 64'(wb_result), 0);
        check("t1 reset wb_error", 64'(wb_error), 0);
        check("t1 reset wb_src", 64'(wb_src), 0);
        cyc(); drive(0, 0, 7'd5, 6'd3, 32'hDEADBEEF); #1;
        check("t1 c1 ready0", 64'(req_ready[0]), 1);
        cyc(); clear_inputs(); #1;
        check("t1 c2 ready0", 64'(req_ready[0]), 1);
        check("t1 c2 wb_valid", 64'(wb_valid), 0);
        cyc(); #1;
        check("t1 c3 wb_valid", 64'(wb_valid), 1);
        check("t1 c3 wb_robid", 64'(wb_robid), 5);
        check("t1 c3 wb_rd", 64'(wb_rd), 3);
        check("t1 c3 wb_result", 64'(wb_result), 64'h00000000DEADBEEF);
        check("t1 c3 wb_src", 64'(wb_src), 0);
        check("t1 c3 ready0", 64'(req_ready[0]), 1);

        // Test 2: all requesters saturating.
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            cyc();
            for (int i = 0; i < NREQ; i++)
                drive(i, 0, 7'($urandom), 6'($urandom), $urandom);
            #1;
            if (c == 1) check("t2 c1 ready", 64'(req_ready), 64'hF);
            if (c >= 2) check("t2 ready rotation", 64'(req_ready), 64'(1 << ((c - 2) % 4)));
            if (c >= 3) begin
                check("t2 wb_valid", 64'(wb_valid), 1);
                check("t2 wb_src", 64'(wb_src), 64'((c - 3) % 4));
            end
        end
        clear_inputs();

        // Test 3: one requester streaming back-to-back.
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            cyc();
            clear_inputs();
            if (c <= 3) drive(2, 0, 7'(10 + c - 1), 6'd1, 32'(c));
            #1;
            if (c <= 3) check("t3 ready2", 64'(req_ready[2]), 1);
            if (c >= 3 && c <= 5) begin
                check("t3 wb_valid", 64'(wb_valid), 1);
                check("t3 wb_robid", 64'(wb_robid), 64'(10 + c - 3));
                check("t3 wb_src", 64'(wb_src), 2);
            end
            if (c == 6) check("t3 c6 wb_valid", 64'(wb_valid), 0);
        end

        // Test 4: flush with buffers 1 and 3 full.
        do_reset();
        cyc(); drive(1, 0, 7'h11, 6'd2, 32'h1111); drive(3, 0, 7'h13, 6'd4, 32'h3333);
        cyc(); clear_inputs(); rob_flush = 1'b1; drive(0, 0, 7'h44, 6'd5, 32'h4444); #1;
        check("t4 flush ready", 64'(req_ready), 0);
        check("t4 flush wb_valid", 64'(wb_valid), 0);
        cyc(); clear_inputs(); #1;
        check("t4 c3 wb_valid", 64'(wb_valid), 0);
        cyc(); drive(1, 0, 7'h33, 6'd6, 32'h5555); #1;
        check("t4 c4 wb_valid", 64'(wb_valid), 0);
        cyc(); clear_inputs(); #1;
        check("t4 c5 wb_valid", 64'(wb_valid), 0);
        cyc(); #1;
        check("t4 c6 wb_valid", 64'(wb_valid), 1);
        check("t4 c6 wb_robid", 64'(wb_robid), 64'h33);
        check("t4 c6 wb_src", 64'(wb_src), 1);

        // Test 5: no-dest rd and error flag pass through.
        do_reset();
        cyc(); drive(1, 1, 7'h7F, 6'h20, 32'h12345678);
        cyc(); clear_inputs();
        cyc(); #1;
        check("t5 wb_valid", 64'(wb_valid), 1);
        check("t5 wb_rd", 64'(wb_rd), 64'h20);
        check("t5 wb_error", 64'(wb_error), 1);
        check("t5 wb_robid", 64'(wb_robid), 64'h7F);
        check("t5 wb_src", 64'(wb_src), 1);

        // Test 6: reset mid-stream.
        do_reset();
        cyc(); for (int i = 0; i < NREQ; i++) drive(i, 1, 7'(i + 1), 6'(i), 32'(i));
        cyc(); clear_inputs(); drive(0, 1, 7'h50, 6'd9, 32'hAA);
        cyc(); clear_inputs(); #1;
        check("t6 c3 wb_valid", 64'(wb_valid), 1);
        rst = 1'b0;
        cyc(); #1;
        check("t6 rst wb_valid", 64'(wb_valid), 0);
        check("t6 rst wb_robid", 64'(wb_robid), 0);
        check("t6 rst wb_error", 64'(wb_error), 0);
        check("t6 rst wb_result", 64'(wb_result), 0);
        check("t6 rst wb_src", 64'(wb_src), 0);
        check("t6 rst ready", 64'(req_ready), 0);
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cyc(); #1;
            check("t6 no stale beat", 64'(wb_valid), 0);
        end

        // Randomized phase.
        begin
            bit [6:0] seq [NREQ];
            for (int i = 0; i < NREQ; i++) seq[i] = 7'(i * 32);
            for (int c = 0; c < 2000; c++) begin
                cyc();
                clear_inputs();
                rst = ($urandom_range(0, 199) != 0);
                rob_flush = ($urandom_range(0, 29) == 0);
                for (int i = 0; i < NREQ; i++) begin
                    if ($urandom_range(0, 2) != 0) begin
                        drive(i, 1'($urandom), seq[i], 6'($urandom), $urandom);
                        seq[i] = seq[i] + 7'd1;
                    end
                end
            end
            cyc();
            clear_inputs();
            rst = 1'b1;
            for (int c = 0; c < 6; c++) cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
